// File: rtl/blackjack_table_fsm.sv
`default_nettype none
// ============================================================================
// Module   : blackjack_table_fsm
// Brief    : N-seat blackjack round controller (deal, seat turns, dealer, settle)
// Revision : 1.0
// ============================================================================
module blackjack_table_fsm #(
   parameter int NUM_SEATS    = 2,
   parameter int SCORE_W      = 5,
   parameter int TARGET       = 21,
   parameter int DEALER_STAND = 17,
   parameter bit HIT_SOFT17   = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         deal_pressed,
   input  logic                         hit_pressed,
   input  logic                         stand_pressed,
   output logic                         card_req,
   input  logic                         card_valid,
   input  logic [3:0]                   card_value,
   output logic [NUM_SEATS*SCORE_W-1:0] seat_scores,
   output logic [SCORE_W-1:0]           dealer_score,
   output logic                         show_dealer_hole,
   output logic [1:0]                   active_seat,
   output logic [2:0]                   game_state,
   output logic [NUM_SEATS*2-1:0]       seat_result,
   output logic [NUM_SEATS-1:0]         seat_blackjack,
   output logic                         round_done
);

   localparam int HANDS      = NUM_SEATS + 1;
   localparam int DEAL_CARDS = 2 * NUM_SEATS + 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DEAL   = 3'd1,
      S_PLAYER = 3'd2,
      S_DEALER = 3'd3,
      S_SETTLE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t                 r_state;
   logic [SCORE_W-1:0]     r_score [HANDS];
   logic [HANDS-1:0]       r_soft;
   logic [SCORE_W-1:0]     r_up;
   logic                   r_card_req;
   logic                   r_add_pend;
   logic [3:0]             r_card;
   logic [2:0]             r_tgt;
   logic [3:0]             r_deal_cnt;
   logic [NUM_SEATS-1:0]   r_bj;
   logic                   r_dealer_bj;
   logic [1:0]             r_active;
   logic [NUM_SEATS*2-1:0] r_result;
   logic                   r_show;
   logic                   r_round_done;

   logic                   w_busy;
   logic [SCORE_W-1:0]     w_cur_score;
   logic                   w_cur_soft;
   logic [SCORE_W:0]       w_sum;
   logic [SCORE_W-1:0]     w_new_score;
   logic                   w_new_soft;
   logic [2:0]             w_deal_tgt;
   logic [SCORE_W-1:0]     w_act_score;
   logic [NUM_SEATS-1:0]   w_at_target;
   logic [NUM_SEATS-1:0]   w_bust;
   logic                   w_all_bust;
   logic                   w_dealer_bust;
   logic                   w_dlr_hit;
   logic                   w_first_ok;
   logic [1:0]             w_first_seat;
   logic                   w_next_ok;
   logic [1:0]             w_next_seat;
   logic [NUM_SEATS*2-1:0] w_settle;

   assign w_busy        = r_card_req | r_add_pend;
   assign w_dealer_bust = r_score[NUM_SEATS] > SCORE_W'(TARGET);
   assign w_all_bust    = &w_bust;
   assign w_dlr_hit     = (r_score[NUM_SEATS] < SCORE_W'(DEALER_STAND)) ||
                          (HIT_SOFT17 && (r_score[NUM_SEATS] == SCORE_W'(DEALER_STAND)) &&
                           r_soft[NUM_SEATS]);

   always_comb begin
      w_cur_score = '0;
      w_cur_soft  = 1'b0;
      w_act_score = '0;
      for (int h = 0; h < HANDS; h++) begin
         if (int'(r_tgt) == h) begin
            w_cur_score = r_score[h];
            w_cur_soft  = r_soft[h];
         end
         if (int'(r_active) == h && h < NUM_SEATS) w_act_score = r_score[h];
      end
   end

   // One soft ace per hand: ace counts 11 only if it cannot bust the hand
   always_comb begin
      w_new_soft = w_cur_soft;
      if (r_card == 4'd1) begin
         if (w_cur_score <= SCORE_W'(TARGET - 11)) begin
            w_sum      = (SCORE_W+1)'(w_cur_score) + (SCORE_W+1)'(11);
            w_new_soft = 1'b1;
         end else begin
            w_sum = (SCORE_W+1)'(w_cur_score) + (SCORE_W+1)'(1);
         end
      end else begin
         w_sum = (SCORE_W+1)'(w_cur_score) + (SCORE_W+1)'(r_card);
         if (w_cur_soft && w_sum > (SCORE_W+1)'(TARGET)) begin
            w_sum      = w_sum - (SCORE_W+1)'(10);
            w_new_soft = 1'b0;
         end
      end
      w_new_score = w_sum[SCORE_W-1:0];
   end

   always_comb begin
      if (int'(r_deal_cnt) < NUM_SEATS)
         w_deal_tgt = r_deal_cnt[2:0];
      else if (int'(r_deal_cnt) == NUM_SEATS || int'(r_deal_cnt) == DEAL_CARDS - 1)
         w_deal_tgt = 3'(NUM_SEATS);
      else
         w_deal_tgt = 3'(int'(r_deal_cnt) - NUM_SEATS - 1);
   end

   always_comb begin
      w_first_ok   = 1'b0;
      w_first_seat = 2'd0;
      w_next_ok    = 1'b0;
      w_next_seat  = 2'd0;
      w_settle     = '0;
      for (int s = NUM_SEATS - 1; s >= 0; s--) begin
         w_at_target[s] = (r_score[s] == SCORE_W'(TARGET));
         w_bust[s]      = (r_score[s] >  SCORE_W'(TARGET));
         if (!w_at_target[s]) begin
            w_first_ok   = 1'b1;
            w_first_seat = 2'(s);
         end
         if (s > int'(r_active) && !r_bj[s]) begin
            w_next_ok   = 1'b1;
            w_next_seat = 2'(s);
         end
         if (w_bust[s])                                 w_settle[2*s +: 2] = 2'b01;
         else if (r_bj[s])                              w_settle[2*s +: 2] = r_dealer_bj ? 2'b11 : 2'b10;
         else if (r_dealer_bj)                          w_settle[2*s +: 2] = 2'b01;
         else if (w_dealer_bust)                        w_settle[2*s +: 2] = 2'b10;
         else if (r_score[s] > r_score[NUM_SEATS])      w_settle[2*s +: 2] = 2'b10;
         else if (r_score[s] == r_score[NUM_SEATS])     w_settle[2*s +: 2] = 2'b11;
         else                                           w_settle[2*s +: 2] = 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_soft       <= '0;
         r_up         <= '0;
         r_card_req   <= 1'b0;
         r_add_pend   <= 1'b0;
         r_card       <= 4'd0;
         r_tgt        <= 3'd0;
         r_deal_cnt   <= 4'd0;
         r_bj         <= '0;
         r_dealer_bj  <= 1'b0;
         r_active     <= 2'd0;
         r_result     <= '0;
         r_show       <= 1'b0;
         r_round_done <= 1'b0;
         for (int h = 0; h < HANDS; h++) r_score[h] <= '0;
      end else begin
         r_round_done <= 1'b0;
         if (r_card_req && card_valid) begin
            r_card     <= card_value;
            r_add_pend <= 1'b1;
            r_card_req <= 1'b0;
         end
         if (r_add_pend) begin
            r_add_pend <= 1'b0;
            for (int h = 0; h < HANDS; h++) begin
               if (int'(r_tgt) == h) begin
                  r_score[h] <= w_new_score;
                  r_soft[h]  <= w_new_soft;
               end
            end
            if (r_state == S_DEAL && int'(r_deal_cnt) == NUM_SEATS + 1) r_up <= w_new_score;
         end
         case (r_state)
            S_IDLE, S_DONE: begin
               if (deal_pressed) begin
                  for (int h = 0; h < HANDS; h++) r_score[h] <= '0;
                  r_soft      <= '0;
                  r_up        <= '0;
                  r_result    <= '0;
                  r_bj        <= '0;
                  r_dealer_bj <= 1'b0;
                  r_show      <= 1'b0;
                  r_active    <= 2'd0;
                  r_deal_cnt  <= 4'd0;
                  r_state     <= S_DEAL;
               end
            end
            S_DEAL: begin
               if (!w_busy) begin
                  if (int'(r_deal_cnt) < DEAL_CARDS) begin
                     r_card_req <= 1'b1;
                     r_tgt      <= w_deal_tgt;
                     r_deal_cnt <= r_deal_cnt + 4'd1;
                  end else begin
                     r_bj <= w_at_target;
                     if (r_score[NUM_SEATS] == SCORE_W'(TARGET)) begin
                        r_dealer_bj <= 1'b1;
                        r_show      <= 1'b1;
                        r_state     <= S_SETTLE;
                     end else if (w_first_ok) begin
                        r_active <= w_first_seat;
                        r_state  <= S_PLAYER;
                     end else begin
                        r_show  <= 1'b1;
                        r_state <= S_DEALER;
                     end
                  end
               end
            end
            S_PLAYER: begin
               if (!w_busy) begin
                  if (w_act_score >= SCORE_W'(TARGET) || (!hit_pressed && stand_pressed)) begin
                     if (w_next_ok) begin
                        r_active <= w_next_seat;
                     end else begin
                        r_active <= 2'd0;
                        r_show   <= 1'b1;
                        r_state  <= S_DEALER;
                     end
                  end else if (hit_pressed) begin
                     r_card_req <= 1'b1;
                     r_tgt      <= 3'(r_active);
                  end
               end
            end
            S_DEALER: begin
               if (!w_busy) begin
                  if (!w_all_bust && w_dlr_hit) begin
                     r_card_req <= 1'b1;
                     r_tgt      <= 3'(NUM_SEATS);
                  end else begin
                     r_state <= S_SETTLE;
                  end
               end
            end
            S_SETTLE: begin
               r_result     <= w_settle;
               r_round_done <= 1'b1;
               r_state      <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   generate
      for (genvar s = 0; s < NUM_SEATS; s++) begin : g_seat
         assign seat_scores[s*SCORE_W +: SCORE_W] = r_score[s];
      end
   endgenerate

   assign card_req         = r_card_req;
   assign dealer_score     = r_show ? r_score[NUM_SEATS] : r_up;
   assign show_dealer_hole = r_show;
   assign active_seat      = r_active;
   assign game_state       = r_state;
   assign seat_result      = r_result;
   assign seat_blackjack   = r_bj;
   assign round_done       = r_round_done;

endmodule
`default_nettype wire
